dmem_mmio: RTL and testbench

Data-side memory responder for the single-cycle CPU. It services the CPU data port: the address from the ALU output, the write strobe, and the store data. It returns load data combinationally in the same cycle.
- Address space: word RAM at the bottom, memory-mapped I/O page at 0xFFFF_0000.
- MMIO contents: LED register, synchronised switch input, a compare timer with interrupt, and a sticky status register.
- Sits beside the CPU at top level; drives the CPU readdata input.

---
 rtl/dmem_mmio.sv | 157 +++++++++++++++
 tb/tb_dmem_mmio.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_mmio.sv
// Data-side memory responder: word RAM at the bottom of the address space and an
// MMIO page at 0xFFFF_0000 with LEDs, switches, a compare timer and a W1C status register.
module dmem_mmio #(
    parameter int ADDR_W = 10,
    parameter int LED_W  = 16,
    parameter int SW_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MemWrite,
    input  logic [31:0]       addr,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    input  logic [SW_W-1:0]   sw,
    output logic [LED_W-1:0]  led,
    output logic              irq
);

    localparam logic [5:0] OFF_LED    = 6'd0;
    localparam logic [5:0] OFF_SW     = 6'd1;
    localparam logic [5:0] OFF_TCNT   = 6'd2;
    localparam logic [5:0] OFF_TCMP   = 6'd3;
    localparam logic [5:0] OFF_TCTRL  = 6'd4;
    localparam logic [5:0] OFF_STATUS = 6'd5;

    logic [31:0]       mem [0:(1<<ADDR_W)-1];

    logic [LED_W-1:0]  led_q,    led_d;
    logic [31:0]       tcnt_q,   tcnt_d;
    logic [31:0]       tcmp_q,   tcmp_d;
    logic [1:0]        tctrl_q,  tctrl_d;
    logic [1:0]        status_q, status_d;
    logic [SW_W-1:0]   sw_meta_q, sw_sync_q;

    logic              ram_hit_s;
    logic              mmio_hit_s;
    logic              mmio_valid_s;
    logic              unmapped_s;
    logic [ADDR_W-1:0] ram_idx_s;
    logic [5:0]        off_s;
    logic              match_set_s;
    logic              berr_set_s;
    logic [1:0]        clr_s;
    logic [31:0]       readdata_s;
    logic              unused_addr_s;

    assign ram_hit_s     = (addr[31:ADDR_W+2] == {(30-ADDR_W){1'b0}});
    assign ram_idx_s     = addr[ADDR_W+1:2];
    assign mmio_hit_s    = (addr[31:8] == 24'hFFFF00);
    assign off_s         = addr[7:2];
    assign mmio_valid_s  = mmio_hit_s && (off_s <= OFF_STATUS);
    assign unmapped_s    = !ram_hit_s && !mmio_valid_s;
    assign unused_addr_s = ^addr[1:0];

    // Load data mux, combinational from address and current register state.
    always_comb begin
        readdata_s = 32'h0000_0000;
        if (ram_hit_s) begin
            readdata_s = mem[ram_idx_s];
        end else if (mmio_hit_s) begin
            case (off_s)
                OFF_LED:    readdata_s = {{(32-LED_W){1'b0}}, led_q};
                OFF_SW:     readdata_s = {{(32-SW_W){1'b0}}, sw_sync_q};
                OFF_TCNT:   readdata_s = tcnt_q;
                OFF_TCMP:   readdata_s = tcmp_q;
                OFF_TCTRL:  readdata_s = {30'd0, tctrl_q};
                OFF_STATUS: readdata_s = {30'd0, status_q};
                default:    readdata_s = 32'h0000_0000;
            endcase
        end else begin
            readdata_s = 32'h0000_0000;
        end
    end

    assign readdata = readdata_s;

    // Next-state for MMIO registers and timer; a TCNT write pre-empts counting and matching.
    always_comb begin
        led_d       = led_q;
        tcnt_d      = tcnt_q;
        tcmp_d      = tcmp_q;
        tctrl_d     = tctrl_q;
        match_set_s = 1'b0;
        clr_s       = 2'b00;
        berr_set_s  = MemWrite && unmapped_s;

        if (MemWrite && mmio_hit_s && (off_s == OFF_LED)) begin
            led_d = writedata[LED_W-1:0];
        end else begin
            led_d = led_q;
        end

        if (MemWrite && mmio_hit_s && (off_s == OFF_TCMP)) begin
            tcmp_d = writedata;
        end else begin
            tcmp_d = tcmp_q;
        end

        if (MemWrite && mmio_hit_s && (off_s == OFF_TCTRL)) begin
            tctrl_d = writedata[1:0];
        end else begin
            tctrl_d = tctrl_q;
        end

        if (MemWrite && mmio_hit_s && (off_s == OFF_STATUS)) begin
            clr_s = writedata[1:0];
        end else begin
            clr_s = 2'b00;
        end

        if (MemWrite && mmio_hit_s && (off_s == OFF_TCNT)) begin
            tcnt_d = writedata;
        end else if (tctrl_q[0] && (tcnt_q == tcmp_q)) begin
            tcnt_d      = 32'h0000_0000;
            match_set_s = 1'b1;
        end else if (tctrl_q[0]) begin
            tcnt_d = tcnt_q + 32'd1;
        end else begin
            tcnt_d = tcnt_q;
        end

        // Hardware set wins over a same-cycle W1C clear.
        status_d = (status_q & ~clr_s) | {berr_set_s, match_set_s};
    end

    // MMIO register and switch synchroniser state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_q     <= {LED_W{1'b0}};
            tcnt_q    <= 32'h0000_0000;
            tcmp_q    <= 32'hFFFF_FFFF;
            tctrl_q   <= 2'b00;
            status_q  <= 2'b00;
            sw_meta_q <= {SW_W{1'b0}};
            sw_sync_q <= {SW_W{1'b0}};
        end else begin
            led_q     <= led_d;
            tcnt_q    <= tcnt_d;
            tcmp_q    <= tcmp_d;
            tctrl_q   <= tctrl_d;
            status_q  <= status_d;
            sw_meta_q <= sw;
            sw_sync_q <= sw_meta_q;
        end
    end

    // RAM store port; contents are never reset and stores are blocked while rst is high.
    always_ff @(posedge clk) begin
        if (MemWrite && ram_hit_s && !rst) begin
            mem[ram_idx_s] <= writedata;
        end
    end

    assign led = led_q;
    assign irq = status_q[0] & tctrl_q[1];

endmodule

// File: tb/tb_dmem_mmio.sv
// Directed self-checking bench for dmem_mmio with hand-computed expectations.
module tb_dmem_mmio;

    localparam logic [31:0] A_LED    = 32'hFFFF_0000;
    localparam logic [31:0] A_SW     = 32'hFFFF_0004;
    localparam logic [31:0] A_TCNT   = 32'hFFFF_0008;
    localparam logic [31:0] A_TCMP   = 32'hFFFF_000C;
    localparam logic [31:0] A_TCTRL  = 32'hFFFF_0010;
    localparam logic [31:0] A_STATUS = 32'hFFFF_0014;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemWrite;
    logic [31:0] addr;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [15:0] sw;
    logic [15:0] led;
    logic        irq;

    int n_checks = 0;
    int n_errors = 0;

    dmem_mmio #(.ADDR_W(10), .LED_W(16), .SW_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .MemWrite  (MemWrite),
        .addr      (addr),
        .writedata (writedata),
        .readdata  (readdata),
        .sw        (sw),
        .led       (led),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        addr      = a;
        writedata = d;
        MemWrite  = 1'b1;
        tick();
        MemWrite  = 1'b0;
    endtask

    task automatic rd_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        check(tag, readdata, exp);
    endtask

    initial begin
        rst       = 1'b1;
        MemWrite  = 1'b0;
        addr      = 32'h0000_0000;
        writedata = 32'h0000_0000;
        sw        = 16'h0000;
        tick();
        tick();
        check("rst_led", {16'h0000, led}, 32'h0000_0000);
        check("rst_irq", {31'd0, irq}, 32'd0);
        rst = 1'b0;
        tick();
        rd_check("rst_tcnt",   A_TCNT,   32'h0000_0000);
        rd_check("rst_tcmp",   A_TCMP,   32'hFFFF_FFFF);
        rd_check("rst_tctrl",  A_TCTRL,  32'h0000_0000);
        rd_check("rst_status", A_STATUS, 32'h0000_0000);

        // RAM access and unmapped read
        do_write(32'h0000_0010, 32'hDEAD_BEEF);
        rd_check("ram_rd",      32'h0000_0010, 32'hDEAD_BEEF);
        rd_check("ram_rd_low",  32'h0000_0013, 32'hDEAD_BEEF);
        rd_check("unmap_rd",    32'h0000_1000, 32'h0000_0000);
        tick();
        rd_check("rd_no_berr",  A_STATUS, 32'h0000_0000);

        // BERR set and W1C clear
        do_write(32'h0000_1000, 32'h0000_0005);
        rd_check("berr_set",    A_STATUS, 32'h0000_0002);
        do_write(A_STATUS, 32'h0000_0002);
        rd_check("berr_clr",    A_STATUS, 32'h0000_0000);
        do_write(32'hFFFF_0040, 32'h0000_0000);
        rd_check("berr_mmio",   A_STATUS, 32'h0000_0002);
        do_write(A_STATUS, 32'h0000_0002);
        do_write(A_SW, 32'hFFFF_FFFF);
        rd_check("sw_wr_nober", A_STATUS, 32'h0000_0000);
        rd_check("sw_wr_noeff", A_SW,     32'h0000_0000);

        // LED and switch synchroniser
        do_write(A_LED, 32'h1234_ABCD);
        check("led_port", {16'h0000, led}, 32'h0000_ABCD);
        rd_check("led_rd", A_LED, 32'h0000_ABCD);
        sw = 16'h00F0;
        rd_check("sw_0edge", A_SW, 32'h0000_0000);
        tick();
        rd_check("sw_1edge", A_SW, 32'h0000_0000);
        tick();
        rd_check("sw_2edge", A_SW, 32'h0000_00F0);

        // Timer compare, MATCH and irq
        do_write(A_TCMP, 32'h0000_0003);
        do_write(A_TCTRL, 32'h0000_0003);
        rd_check("tcnt_0", A_TCNT, 32'h0000_0000);
        for (int i = 1; i <= 3; i++) begin
            tick();
            rd_check("tcnt_cnt", A_TCNT, i);
            rd_check("no_match", A_STATUS, 32'h0000_0000);
            check("irq_low", {31'd0, irq}, 32'd0);
        end
        tick();
        rd_check("tcnt_wrap", A_TCNT, 32'h0000_0000);
        rd_check("match_set", A_STATUS, 32'h0000_0001);
        check("irq_high", {31'd0, irq}, 32'd1);
        rd_check("tctrl_rd", A_TCTRL, 32'h0000_0003);
        do_write(A_STATUS, 32'h0000_0001);
        check("irq_clr", {31'd0, irq}, 32'd0);
        rd_check("tcnt_after_clr", A_TCNT, 32'h0000_0001);
        tick();
        tick();
        rd_check("tcnt_3", A_TCNT, 32'h0000_0003);
        do_write(A_STATUS, 32'h0000_0001);
        rd_check("set_beats_clr", A_STATUS, 32'h0000_0001);
        check("irq_set_beats", {31'd0, irq}, 32'd1);
        do_write(A_STATUS, 32'h0000_0001);
        rd_check("clr_again", A_STATUS, 32'h0000_0000);
        do_write(A_TCTRL, 32'h0000_0001);
        tick();
        tick();
        rd_check("match_no_ie", A_STATUS, 32'h0000_0001);
        check("irq_no_ie", {31'd0, irq}, 32'd0);
        do_write(A_STATUS, 32'h0000_0001);

        // Wrap without match, exact TCNT load, EN freeze
        do_write(A_TCTRL, 32'h0000_0000);
        do_write(A_TCMP,  32'h0000_0010);
        do_write(A_TCNT,  32'hFFFF_FFFE);
        rd_check("tcnt_load", A_TCNT, 32'hFFFF_FFFE);
        do_write(A_TCTRL, 32'h0000_0001);
        rd_check("tcnt_frozen", A_TCNT, 32'hFFFF_FFFE);
        tick();
        rd_check("tcnt_max", A_TCNT, 32'hFFFF_FFFF);
        tick();
        rd_check("tcnt_ovf", A_TCNT, 32'h0000_0000);
        rd_check("ovf_no_match", A_STATUS, 32'h0000_0000);
        do_write(A_TCNT, 32'h0000_0100);
        rd_check("tcnt_wr_cnt", A_TCNT, 32'h0000_0100);
        tick();
        rd_check("tcnt_inc", A_TCNT, 32'h0000_0101);
        do_write(A_TCTRL, 32'h0000_0000);
        tick();
        rd_check("tcnt_en0", A_TCNT, 32'h0000_0102);

        // Reset mid-operation
        do_write(A_TCMP, 32'h0000_0020);
        do_write(A_TCNT, 32'h0000_0020);
        do_write(A_TCTRL, 32'h0000_0003);
        tick();
        check("irq_pre_rst", {31'd0, irq}, 32'd1);
        addr      = A_LED;
        writedata = 32'h0000_5555;
        MemWrite  = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_led", {16'h0000, led}, 32'h0000_0000);
        check("rst_async_irq", {31'd0, irq}, 32'd0);
        tick();
        check("rst_blocks_wr", {16'h0000, led}, 32'h0000_0000);
        addr      = 32'h0000_0010;
        writedata = 32'h0000_0000;
        tick();
        MemWrite = 1'b0;
        rd_check("rst_tcnt2", A_TCNT, 32'h0000_0000);
        rd_check("rst_tcmp2", A_TCMP, 32'hFFFF_FFFF);
        rst = 1'b0;
        tick();
        rd_check("ram_kept", 32'h0000_0010, 32'hDEAD_BEEF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
